conv_window_mac: RTL and testbench



---
 rtl/conv_window_mac.sv | 208 ++++++++++++++++++++
 tb/tb_conv_window_mac.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_mac.sv
`timescale 1ns/1ps
// 3x3 sliding-window multiply-accumulate over a column-ordered pixel stream.
// Signed kernel, arithmetic shift, saturation to 12 bits, 3-cycle compute pipeline.
module conv_window_mac #(
  parameter int NUM_COLS = 5,
  parameter int NUM_ROWS = 5,
  parameter int SHIFT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [11:0]       d_in,
  input  logic              coef_we,
  input  logic [3:0]        coef_addr,
  input  logic signed [7:0] coef_data,
  output logic              out_valid,
  output logic [11:0]       d_out,
  output logic [16:0]       addr_wr,
  output logic              done
);
  localparam int DATA_W = 12;
  localparam int COEF_W = 8;
  localparam int PROD_W = 21;
  localparam int SUM_W  = 25;
  localparam int CW     = $clog2(NUM_COLS);
  localparam int RW     = $clog2(NUM_ROWS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q;
  logic [1:0]      pix_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic [1:0]      drain_q;
  logic            done_q;

  logic [DATA_W-1:0]        colr_q [3];
  logic [DATA_W-1:0]        colr_d [3];
  logic [DATA_W-1:0]        win_q [9];
  logic [DATA_W-1:0]        win_d [9];
  logic signed [COEF_W-1:0] coef_q [9];
  logic signed [COEF_W-1:0] coef_d [9];
  logic signed [PROD_W-1:0] prod_p1_q [9];
  logic signed [PROD_W-1:0] prod_p1_d [9];
  logic signed [SUM_W-1:0]  sum_p2_q, sum_p2_d;
  logic                     vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        d_out_q, d_out_d;
  logic [16:0]              addr_wr_q, addr_wr_d, addr_cnt_q, addr_cnt_d;

  logic accept, col_done, run_entry, coef_open;

  function automatic logic [DATA_W-1:0] saturate(input logic signed [SUM_W-1:0] v);
    if (v < 0)              return '0;
    else if (v > 25'sd4095) return '1;
    else                    return v[DATA_W-1:0];
  endfunction

  assign coef_open = (state_q == S_IDLE) || (state_q == S_DONE);
  assign run_entry = start && coef_open;
  assign accept    = (state_q == S_RUN) && in_valid;
  assign col_done  = accept && (pix_q == 2'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_RUN;
            pix_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (in_valid) begin
            if (pix_q == 2'd2) begin
              pix_q <= '0;
              if (col_q == CW'(NUM_COLS - 1)) begin
                col_q <= '0;
                if (row_q == RW'(NUM_ROWS - 3)) begin
                  state_q <= S_DRAIN;
                  drain_q <= '0;
                end else begin
                  row_q <= row_q + RW'(1);
                end
              end else begin
                col_q <= col_q + CW'(1);
              end
            end else begin
              pix_q <= pix_q + 2'd1;
            end
          end
        end
        S_DRAIN: begin
          // done lands the cycle after the final out_valid pulse
          if (drain_q == 2'd3) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // p0: column capture and window shift
  always_comb begin
    colr_d   = colr_q;
    win_d    = win_q;
    coef_d   = coef_q;
    vld_p0_d = 1'b0;
    if (accept) begin
      colr_d[0] = colr_q[1];
      colr_d[1] = colr_q[2];
      colr_d[2] = d_in;
    end
    if (col_done) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r*3]   = win_q[r*3+1];
        win_d[r*3+1] = win_q[r*3+2];
      end
      win_d[2] = colr_q[1];
      win_d[5] = colr_q[2];
      win_d[8] = d_in;
      vld_p0_d = (col_q >= CW'(2));
    end
    if (coef_open && coef_we) begin
      for (int i = 0; i < 9; i++)
        if (coef_addr == 4'(i)) coef_d[i] = coef_data;
    end
  end

  // p1: products; p2: sum
  always_comb begin
    sum_p2_d = '0;
    for (int i = 0; i < 9; i++) begin
      prod_p1_d[i] = $signed({{(PROD_W-DATA_W){1'b0}}, win_q[i]}) * PROD_W'(coef_q[i]);
      sum_p2_d     = sum_p2_d + SUM_W'(prod_p1_q[i]);
    end
  end

  // p3: normalise, saturate, address
  always_comb begin
    vld_p1_d    = vld_p0_q;
    vld_p2_d    = vld_p1_q;
    out_valid_d = vld_p2_q;
    d_out_d     = d_out_q;
    addr_wr_d   = addr_wr_q;
    addr_cnt_d  = addr_cnt_q;
    if (run_entry) addr_cnt_d = '0;
    if (vld_p2_q) begin
      d_out_d    = saturate(sum_p2_q >>> SHIFT);
      addr_wr_d  = addr_cnt_q;
      addr_cnt_d = addr_cnt_q + 17'd1;
    end
  end

  always_ff @(posedge clk) begin
    prod_p1_q <= prod_p1_d;
    sum_p2_q  <= sum_p2_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) colr_q[i] <= '0;
      for (int i = 0; i < 9; i++) begin
        win_q[i]  <= '0;
        coef_q[i] <= (i == 4) ? COEF_W'(1 << SHIFT) : '0;
      end
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      d_out_q     <= '0;
      addr_wr_q   <= '0;
      addr_cnt_q  <= '0;
    end else begin
      colr_q      <= colr_d;
      win_q       <= win_d;
      coef_q      <= coef_d;
      vld_p0_q    <= vld_p0_d;
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      out_valid_q <= out_valid_d;
      d_out_q     <= d_out_d;
      addr_wr_q   <= addr_wr_d;
      addr_cnt_q  <= addr_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign d_out     = d_out_q;
  assign addr_wr   = addr_wr_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_window_mac.sv
`timescale 1ns/1ps
// Randomised bench for conv_window_mac: frames are scored against a direct
// 3x3 convolution of the streamed image, including output latency and done timing.
module tb_conv_window_mac;
  localparam int NC = 5;
  localparam int NR = 5;
  localparam int SH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [11:0]       d_in = '0;
  logic              coef_we = 1'b0;
  logic [3:0]        coef_addr = '0;
  logic signed [7:0] coef_data = '0;
  logic              out_valid;
  logic [11:0]       d_out;
  logic [16:0]       addr_wr;
  logic              done;

  conv_window_mac #(.NUM_COLS(NC), .NUM_ROWS(NR), .SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .d_in(d_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .d_out(d_out), .addr_wr(addr_wr), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, $signed(got), $signed(want), cyc);
    end
  endtask

  typedef struct { int addr; int val; } exp_t;
  int   img [NR][NC];
  int   kern [9];
  exp_t exp_q [$];
  int   edge_q [$];
  int   obs_q [$];
  int   ramp_exp [9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
  int   last_ov = -100;
  bit   done_prev = 1'b0;
  exp_t m_e;
  int   m_ed;

  function automatic int sat12(input int v);
    if (v < 0) return 0;
    if (v > 4095) return 4095;
    return v;
  endfunction

  task automatic build_expected();
    for (int r = 0; r < NR - 2; r++)
      for (int c = 0; c < NC - 2; c++) begin
        int acc = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            acc += kern[i*3+j] * img[r+i][c+j];
        exp_q.push_back('{r * (NC - 2) + c, sat12(acc >>> SH)});
      end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      done_prev = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("spurious_out_valid", 1, 0);
        else begin
          m_e = exp_q.pop_front();
          check("d_out", 32'(d_out), m_e.val);
          check("addr_wr", 32'(addr_wr), m_e.addr);
        end
        if (edge_q.size() > 0) begin
          m_ed = edge_q.pop_front();
          check("latency", cyc - m_ed, 3);
        end
        obs_q.push_back(int'(d_out));
        last_ov = cyc;
      end
      if (done && !done_prev) check("done_after_last_pulse", cyc - last_ov, 1);
      done_prev = done;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_identity();
    foreach (kern[i]) kern[i] = 0;
    kern[4] = 1 << SH;
  endtask

  task automatic set_kernel();
    for (int i = 0; i < 10; i++) begin
      coef_we = 1'b1;
      if (i < 9) begin
        coef_addr = 4'(i);
        coef_data = 8'(kern[i]);
      end else begin
        coef_addr = 4'(9 + $urandom_range(0, 6));
        coef_data = 8'($urandom);
      end
      step();
    end
    coef_we = 1'b0;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) img[r][c] = NC * r + c;
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) img[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) img[r][c] = $urandom_range(0, 4095);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    check("done_clear_on_start", 32'(done), 0);
  endtask

  task automatic stream(input bit gaps, input bit coef_noise, input bit glitch, input int max_pix);
    int n = 0;
    for (int r = 0; r < NR - 2; r++)
      for (int c = 0; c < NC; c++)
        for (int k = 0; k < 3; k++) begin
          int g;
          if (n == max_pix) begin
            in_valid = 1'b0;
            return;
          end
          g = 0;
          if (gaps) g = (n == 20) ? 10 : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
          repeat (g) begin
            in_valid = 1'b0;
            d_in = 12'($urandom);
            coef_we = 1'b0;
            step();
          end
          in_valid  = 1'b1;
          d_in      = 12'(img[r+k][c]);
          coef_we   = coef_noise ? 1'($urandom_range(0, 1)) : 1'b0;
          coef_addr = 4'($urandom);
          coef_data = 8'($urandom);
          start     = glitch && (n == 30);
          if (k == 2 && c >= 2) edge_q.push_back(cyc + 1);
          step();
          n++;
        end
    in_valid = 1'b0;
    coef_we  = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 80) begin
      step();
      t++;
    end
    check("done_seen", 32'(done), 1);
    check("all_outputs_seen", exp_q.size(), 0);
  endtask

  task automatic run_frame(input bit gaps, input bit coef_noise, input bit glitch);
    in_valid = 1'b1;
    d_in = 12'($urandom);
    step();
    in_valid = 1'b0;
    build_expected();
    obs_q.delete();
    do_start();
    stream(gaps, coef_noise, glitch, 1000);
    wait_done();
  endtask

  task automatic check_ramp_values();
    check("ramp_count", obs_q.size(), 9);
    for (int i = 0; i < 9; i++)
      check("ramp_value", (i < obs_q.size()) ? obs_q[i] : -1, ramp_exp[i]);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_d_out", 32'(d_out), 0);
    check("rst_addr_wr", 32'(addr_wr), 0);
    check("rst_done", 32'(done), 0);
    rst = 1'b1;
    step();

    set_identity();
    fill_ramp();
    run_frame(1'b0, 1'b0, 1'b0);
    check_ramp_values();

    run_frame(1'b1, 1'b0, 1'b1);
    check_ramp_values();

    foreach (kern[i]) kern[i] = 1;
    set_kernel();
    fill_const(160);
    run_frame(1'b0, 1'b0, 1'b0);

    foreach (kern[i]) kern[i] = 127;
    set_kernel();
    fill_const(4095);
    run_frame(1'b0, 1'b0, 1'b0);

    foreach (kern[i]) kern[i] = 0;
    kern[4] = -16;
    set_kernel();
    fill_rand();
    run_frame(1'b0, 1'b0, 1'b0);

    for (int f = 0; f < 3; f++) begin
      foreach (kern[i]) kern[i] = $urandom_range(0, 255) - 128;
      set_kernel();
      fill_rand();
      run_frame(f == 1, f != 0, 1'b0);
    end

    foreach (kern[i]) kern[i] = $urandom_range(0, 255) - 128;
    set_kernel();
    fill_rand();
    build_expected();
    do_start();
    stream(1'b0, 1'b0, 1'b0, 20);
    rst = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_d_out", 32'(d_out), 0);
    check("abort_addr_wr", 32'(addr_wr), 0);
    check("abort_done", 32'(done), 0);
    step();
    step();
    exp_q.delete();
    edge_q.delete();
    rst = 1'b1;
    repeat (15) begin
      in_valid = 1'($urandom_range(0, 1));
      d_in = 12'($urandom);
      step();
      check("post_abort_out_valid", 32'(out_valid), 0);
      check("post_abort_d_out", 32'(d_out), 0);
    end
    in_valid = 1'b0;
    set_identity();
    fill_ramp();
    run_frame(1'b0, 1'b0, 1'b0);
    check_ramp_values();

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
